hilo_aware_decode: RTL and testbench

Registered, handshaked successor to the combinational main decoder: decodes a 32-bit MIPS instruction into the control bundle in one pipeline cycle and holds it in a one-entry output register with valid/ready flow control. It adds link-jump decode (JAL/JR/JALR), a reserved-instruction flag, and an HI/LO busy scoreboard. The scoreboard stalls MFHI/MFLO and further HI/LO writers until the multi-cycle multiply or divide issued earlier has finished. It sits between fetch and the register-read/execute stage.

---
 rtl/hilo_aware_decode.sv | 139 +++++++++++++
 tb/tb_hilo_aware_decode.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_aware_decode.sv
// Registered MIPS main decoder: 1-cycle latency into a one-entry valid/ready output register.
// Stalls MFHI/MFLO and HI/LO writers while a multiply/divide result is pending or a HI/LO writer is held.
module hilo_aware_decode #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        memtoreg,
  output logic        memwrite,
  output logic        branch,
  output logic        alusrc,
  output logic        regdst,
  output logic        regwrite,
  output logic        jump,
  output logic        hilowrite,
  output logic        memsignext,
  output logic        link,
  output logic        jumpreg,
  output logic        ri,
  output logic [1:0]  membyte,
  output logic        hilo_busy
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef struct packed {
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       jump;
    logic       hilowrite;
    logic       memsignext;
    logic       link;
    logic       jumpreg;
    logic       ri;
    logic [1:0] membyte;
    logic       is_mul;
    logic       is_div;
  } ctrl_t;

  logic [5:0]    op, funct;
  ctrl_t         dec, held;
  logic [CW-1:0] cnt;
  logic          hilo_read, hazard, accept, issue;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    dec            = '0;
    dec.memsignext = 1'b1;
    casez (op)
      6'b100011: begin dec.memtoreg = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1; end
      6'b100000: begin dec.memtoreg = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.membyte = 2'd2; end
      6'b100100: begin
        dec.memtoreg = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
        dec.membyte = 2'd2; dec.memsignext = 1'b0;
      end
      6'b100001: begin dec.memtoreg = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.membyte = 2'd1; end
      6'b100101: begin
        dec.memtoreg = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
        dec.membyte = 2'd1; dec.memsignext = 1'b0;
      end
      6'b101011: begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; end
      6'b101000: begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; dec.membyte = 2'd2; end
      6'b101001: begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; dec.membyte = 2'd1; end
      6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001: dec.branch = 1'b1;
      6'b001???: begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
      6'b000010: dec.jump = 1'b1;
      6'b000011: begin dec.jump = 1'b1; dec.link = 1'b1; dec.regwrite = 1'b1; end
      6'b000000: begin
        dec.regdst = 1'b1;
        case (funct)
          6'b011000, 6'b011001: begin dec.hilowrite = 1'b1; dec.is_mul = 1'b1; end
          6'b011010, 6'b011011: begin dec.hilowrite = 1'b1; dec.is_div = 1'b1; end
          6'b010001, 6'b010011: dec.hilowrite = 1'b1;
          6'b001000:            dec.jumpreg = 1'b1;
          6'b001001: begin dec.jumpreg = 1'b1; dec.link = 1'b1; dec.regwrite = 1'b1; end
          default:              dec.regwrite = 1'b1;
        endcase
      end
      default: dec.ri = 1'b1;
    endcase
  end

  // A held HI/LO writer has not started its counter yet, so it blocks dependents too.
  assign hilo_read = (op == 6'b000000) && ((funct == 6'b010000) || (funct == 6'b010010));
  assign hazard    = (hilo_read || dec.hilowrite) &&
                     ((cnt != '0) || (out_valid && held.hilowrite));
  assign in_ready  = !rst && !flush && !hazard && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (issue) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (issue && held.is_mul) cnt <= CW'(MUL_CYCLES);
    else if (issue && held.is_div) cnt <= CW'(DIV_CYCLES);
    else if (cnt != '0)            cnt <= cnt - 1'b1;
  end

  assign hilo_busy  = (cnt != '0);
  assign memtoreg   = held.memtoreg;
  assign memwrite   = held.memwrite;
  assign branch     = held.branch;
  assign alusrc     = held.alusrc;
  assign regdst     = held.regdst;
  assign regwrite   = held.regwrite;
  assign jump       = held.jump;
  assign hilowrite  = held.hilowrite;
  assign memsignext = held.memsignext;
  assign link       = held.link;
  assign jumpreg    = held.jumpreg;
  assign ri         = held.ri;
  assign membyte    = held.membyte;
endmodule

// File: tb/tb_hilo_aware_decode.sv
// Scoreboard bench for hilo_aware_decode: driver pushes expected bundles on accept, monitor pops on issue.
module tb_hilo_aware_decode;
  localparam int MUL = 4;
  localparam int DIV = 32;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, hilowrite, memsignext;
  logic link, jumpreg, ri, hilo_busy;
  logic [1:0] membyte;

  hilo_aware_decode #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .memtoreg(memtoreg), .memwrite(memwrite), .branch(branch), .alusrc(alusrc),
    .regdst(regdst), .regwrite(regwrite), .jump(jump), .hilowrite(hilowrite),
    .memsignext(memsignext), .link(link), .jumpreg(jumpreg), .ri(ri),
    .membyte(membyte), .hilo_busy(hilo_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, hilowrite;
    logic memsignext, link, jumpreg, ri;
    logic [1:0] membyte;
  } exp_t;
  typedef struct packed {
    logic [1:0] kind;  // 1 = multiply, 2 = divide
    exp_t       e;
  } ent_t;

  ent_t q[$];
  int   mcnt = 0;
  int   n_checks = 0, n_fail = 0;
  logic acc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference decode written per output from the opcode/funct tables.
  function automatic ent_t model(input logic [31:0] i);
    logic [5:0] op, f;
    logic rt, ld, st, br, im, hw, known;
    ent_t r;
    op = i[31:26]; f = i[5:0];
    rt = (op == 6'h00);
    ld = op inside {6'h23, 6'h20, 6'h24, 6'h21, 6'h25};
    st = op inside {6'h2b, 6'h28, 6'h29};
    br = op inside {6'h04, 6'h05, 6'h06, 6'h07, 6'h01};
    im = (op >= 6'h08) && (op <= 6'h0f);
    hw = rt && (f inside {6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13});
    known = rt || ld || st || br || im || op == 6'h02 || op == 6'h03;
    r.e.memtoreg   = ld;
    r.e.memwrite   = st;
    r.e.branch     = br;
    r.e.alusrc     = ld || st || im;
    r.e.regdst     = rt;
    r.e.regwrite   = ld || im || op == 6'h03 || (rt && !hw && f != 6'h08);
    r.e.jump       = (op == 6'h02) || (op == 6'h03);
    r.e.hilowrite  = hw;
    r.e.memsignext = !(op inside {6'h24, 6'h25});
    r.e.link       = (op == 6'h03) || (rt && f == 6'h09);
    r.e.jumpreg    = rt && (f inside {6'h08, 6'h09});
    r.e.ri         = !known;
    r.e.membyte    = (op inside {6'h20, 6'h24, 6'h28}) ? 2'd2 :
                     (op inside {6'h21, 6'h25, 6'h29}) ? 2'd1 : 2'd0;
    r.kind = (rt && f inside {6'h18, 6'h19}) ? 2'd1 :
             (rt && f inside {6'h1a, 6'h1b}) ? 2'd2 : 2'd0;
    return r;
  endfunction

  function automatic logic needs_hilo(input logic [31:0] i);
    ent_t r;
    r = model(i);
    return (i[31:26] == 6'h00 && (i[5:0] == 6'h10 || i[5:0] == 6'h12)) || r.e.hilowrite;
  endfunction

  // Monitor: checks handshake and scoreboard state each cycle, pops on issue.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      logic exp_rdy;
      exp_t got;
      exp_rdy = !flush && (q.size() == 0 || out_ready) &&
                !(needs_hilo(instr) && (mcnt != 0 || (q.size() != 0 && q[0].e.hilowrite)));
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("hilo_busy", {31'd0, hilo_busy}, {31'd0, mcnt != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (flush) begin
        q.delete();
        if (mcnt > 0) mcnt--;
      end else if (q.size() != 0 && out_ready) begin
        got = '{memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, hilowrite,
                memsignext, link, jumpreg, ri, membyte};
        chk("bundle", {18'd0, got}, {18'd0, q[0].e});
        if (q[0].kind == 2'd1)      mcnt = MUL;
        else if (q[0].kind == 2'd2) mcnt = DIV;
        else if (mcnt > 0)          mcnt--;
        void'(q.pop_front());
      end else if (mcnt > 0) begin
        mcnt--;
      end
    end
  end

  // One clock: record acceptance just after the monitor's sample, return #1 after the edge.
  task automatic cyc();
    @(negedge clk);
    #1;
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(instr));
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i);
    instr = i; in_valid = 1'b1;
    cyc();
    chk("accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [11:0] tbl [28];
    logic [31:0] r;
    int k;
    tbl = '{12'h018, 12'h019, 12'h01a, 12'h01b, 12'h010, 12'h012, 12'h011, 12'h013,
            12'h008, 12'h009, 12'h020, 12'h8c0, 12'h800, 12'h900, 12'h840, 12'h940,
            12'hac0, 12'ha00, 12'ha40, 12'h100, 12'h040, 12'h300, 12'h3c0, 12'h200,
            12'h080, 12'h0c0, 12'hfc0, 12'h000};
    r = $urandom;
    k = $urandom_range(0, 29);
    if (k < 28) begin
      r[31:26] = tbl[k][11:6];
      if (tbl[k][11:6] == 6'h00) r[5:0] = tbl[k][5:0];
    end
    return r;
  endfunction

  initial begin
    int stall;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_hilo_busy", {31'd0, hilo_busy}, 32'd0);
    chk("rst_controls", {16'd0, memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump,
        hilowrite, memsignext, link, jumpreg, ri, membyte, 2'b00}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    out_ready = 1'b1;
    offer(32'h8C220004);
    chk("lw_latency", {31'd0, out_valid}, 32'd1);
    offer(32'h90220000);
    offer(32'hA4220000);
    offer(32'h0C000010);
    offer(32'h00A0F809);
    offer(32'hFC000000);
    cyc();

    // Divide then a continuously offered MFLO.
    offer(32'h0085001A);
    cyc();
    instr = 32'h00001012; in_valid = 1'b1; stall = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (acc) break;
      stall++;
    end
    chk("div_stall", stall, DIV);
    in_valid = 1'b0;
    cyc();

    // MULT held while MFHI waits, then MUL_CYCLES more after it issues.
    out_ready = 1'b0;
    offer(32'h00850018);
    instr = 32'h00001010; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mfhi_held_stall", {31'd0, acc}, 32'd0);
    end
    out_ready = 1'b1; stall = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (acc) break;
      stall++;
    end
    chk("mul_stall", stall, MUL + 1);
    in_valid = 1'b0;
    cyc(); cyc();

    // Flushed divide never issues or starts the counter.
    out_ready = 1'b0;
    offer(32'h0085001A);
    flush = 1'b1;
    cyc();
    flush = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    chk("flush_busy", {31'd0, hilo_busy}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a divide with an entry held.
    offer(32'h0085001A);
    cyc(); cyc(); cyc();
    out_ready = 1'b0;
    offer(32'h8C220004);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, hilo_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 80);
      out_ready = ($urandom_range(0, 99) < 75);
      flush     = ($urandom_range(0, 99) < 4);
      instr     = pick();
      cyc();
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || hilo_busy); i++) cyc();
    chk("drain", {31'd0, q.size() != 0 || hilo_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
